agp32_mem_bridge: RTL and testbench
===================================

Name: agp32_mem_bridge

Overview:
- Memory-side bridge directly downstream of the agp32 pipeline core.
- Accepts the core's one-cycle `command` pulses (fetch, data read, data write, interrupt) and serialises them onto a single-port word-addressed backing memory with a req/gnt/rvalid handshake.
- Returns `ready`, `inst_rdata` and `data_rdata` to the core; reports `mem_start_ready` after power-up initialisation and a sticky `error` code.

Parameters:
- ADDR_W, 16: word-address width of the backing memory port; byte space is 2^(ADDR_W+2) bytes.
- INIT_CYCLES, 8: cycles after reset release before `mem_start_ready` asserts.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- command  in  3  core request: 0 none, 1 inst fetch, 2 data read, 3 data write, 4 interrupt; 5-7 illegal.
- pc  in  32  byte address for fetch.
- data_addr  in  32  byte address for read/write.
- data_wdata  in  32  write data.
- data_wstrb  in  4  byte enables for write.
- ready  out  1  bridge idle; core may issue.
- inst_rdata  out  32  last fetched instruction.
- data_rdata  out  32  last read data word.
- mem_start_ready  out  1  initialisation complete.
- error  out  2  0 ok, 1 out of range, 2 misaligned word write, 3 illegal command.
- mem_req  out  1  backing memory request.
- mem_we  out  1  write request.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  byte enables.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid; 1+ cycles after gnt.
- mem_rdata  in  32  read data.

Behaviour:
- Reset values:
  - state INIT; `ready` 0, `mem_start_ready` 0, `error` 0, `mem_req` 0, `mem_we` 0.
  - `inst_rdata` 32'd63 (pipeline NOP); `data_rdata` 0; `mem_addr`, `mem_wdata`, `mem_wstrb` 0.
  - Reset mid-transaction aborts immediately; outstanding `mem_rvalid` after reset is ignored.
- All outputs are registered.
- INIT: counter counts INIT_CYCLES cycles, then `mem_start_ready` goes 1 (stays 1 until reset) and the state moves to IDLE.
  - Commands seen in INIT are ignored.
- IDLE: `ready` 1. On a cycle with `command` != 0, latch command, `pc`, `data_addr`, `data_wdata`, `data_wstrb`.
  - `ready` drops to 0 on the following edge.
  - The core drops `command` to 0 one cycle later; the bridge acts only on the IDLE-cycle value and never re-triggers while busy.
- Checks at latch time, in priority order; the first hit applies:
  - command 5-7: `error` = 3.
  - target word address >= 2^ADDR_W: `error` = 1.
  - command 3 with wstrb = 4'hF and addr[1:0] != 0: `error` = 2.
  - On any hit: no memory access, go to ERR.
- ISSUE: drive `mem_req` = 1 with `mem_addr`, `mem_we`, `mem_wdata` and `mem_wstrb` held stable until `mem_gnt`.
  - Command 1 uses pc[ADDR_W+1:2]; commands 2 and 3 use data_addr[ADDR_W+1:2]. Low bits are ignored for reads; byte extraction is done by the core.
  - On `gnt`: a write (cmd 3) goes to DONE; a read (cmd 1/2) drops `mem_req` and goes to WAIT_R.
- Command 4: no memory access, goes straight to DONE.
- WAIT_R: on `mem_rvalid`, load `mem_rdata` into `inst_rdata` (cmd 1) or `data_rdata` (cmd 2), then go to DONE.
- DONE: one cycle with `ready` 0, then IDLE with `ready` 1. Minimum command-to-`ready` latency is 3 cycles for cmd 4.
- ERR: `ready` held 0 and `error` holds its code until reset. The core freezes on a nonzero `error`.
- `inst_rdata` and `data_rdata` hold their values between updates. The core samples `inst_rdata` only while `ready` is 1.
- Write strobes are passed through unchanged; a strobe of 0 still completes via `gnt`.

Test Plan:
- Reset release, INIT_CYCLES=8 -> `mem_start_ready` 0 for 8 cycles then 1; `ready` 1 the same cycle; `inst_rdata` 32'h3F.
- cmd 1, pc 0x10, memory word 4 = 0xDEADBEEF, gnt immediate, rvalid 2 cycles later -> `mem_addr` 4, `mem_we` 0; `inst_rdata` 0xDEADBEEF; `ready` returns 1 exactly one cycle after rvalid.
- cmd 3, addr 0x21, wstrb 4'b0010, wdata 0x0000AB00, gnt delayed 3 cycles -> `mem_req` held 3 cycles with `mem_addr` 8 and `wstrb` 0010 stable; `ready` 1 after DONE.
- cmd 3, addr 0x22, wstrb 4'hF -> `error` 2, no `mem_req`, `ready` stays 0; reset clears `error`.
- cmd 2, addr 0x40000 with ADDR_W=16 -> `error` 1, no access. Separately, cmd 6 -> `error` 3.
- cmd 2 in flight, `rst_n` asserted before rvalid -> all outputs return to reset values immediately; a late rvalid does not change `data_rdata`.

Source files
------------

// File: rtl/agp32_mem_bridge.sv
// Memory-side bridge for the agp32 core: serialises fetch/read/write/interrupt
// commands onto a single-port word-addressed memory with req/gnt/rvalid.
module agp32_mem_bridge #(
    parameter int ADDR_W      = 16,
    parameter int INIT_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        command,
    input  logic [31:0]       pc,
    input  logic [31:0]       data_addr,
    input  logic [31:0]       data_wdata,
    input  logic [3:0]        data_wstrb,
    output logic              ready,
    output logic [31:0]       inst_rdata,
    output logic [31:0]       data_rdata,
    output logic              mem_start_ready,
    output logic [1:0]        error,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    // state    | meaning
    // S_INIT   | power-up delay, commands ignored
    // S_IDLE   | ready, waiting for a command
    // S_DECODE | checking the latched command
    // S_ISSUE  | mem_req held until mem_gnt
    // S_WAIT_R | read granted, waiting for mem_rvalid
    // S_DONE   | one busy cycle before returning to idle
    // S_ERR    | error latched, frozen until reset
    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_DECODE, S_ISSUE, S_WAIT_R, S_DONE, S_ERR
    } state_t;

    localparam int               CNT_W    = $clog2(INIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(INIT_CYCLES - 1);

    state_t            state, state_d;
    logic [CNT_W-1:0]  init_cnt, init_cnt_d;
    logic [2:0]        cmd_q, cmd_d;
    logic [29:0]       pc_q, pc_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              ready_d, msr_d, mem_req_d, mem_we_d;
    logic [1:0]        error_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [31:0]       mem_wdata_d, inst_d, data_d;
    logic [3:0]        mem_wstrb_d;
    logic [29:0]       tgt_word;
    logic              out_of_range, misaligned;

    assign tgt_word     = (cmd_q == 3'd1) ? pc_q : addr_q[31:2];
    assign out_of_range = (tgt_word[29:ADDR_W] != '0);
    assign misaligned   = (cmd_q == 3'd3) && (wstrb_q == 4'hF) && (addr_q[1:0] != 2'b00);

    always_comb begin
        state_d     = state;
        init_cnt_d  = init_cnt;
        cmd_d       = cmd_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        msr_d       = mem_start_ready;
        error_d     = error;
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        mem_wstrb_d = mem_wstrb;
        inst_d      = inst_rdata;
        data_d      = data_rdata;
        case (state)
            S_INIT: begin
                if (init_cnt == '0) begin
                    state_d = S_IDLE;
                    msr_d   = 1'b1;
                end else begin
                    init_cnt_d = init_cnt - 1'b1;
                end
            end
            S_IDLE: begin
                if (command != 3'd0) begin
                    state_d = S_DECODE;
                    cmd_d   = command;
                    pc_d    = pc[31:2];
                    addr_d  = data_addr;
                    wdata_d = data_wdata;
                    wstrb_d = data_wstrb;
                end
            end
            S_DECODE: begin
                // Interrupts carry no address, so they bypass the range check.
                if (cmd_q >= 3'd5) begin
                    error_d = 2'd3;
                    state_d = S_ERR;
                end else if (cmd_q == 3'd4) begin
                    state_d = S_DONE;
                end else if (out_of_range) begin
                    error_d = 2'd1;
                    state_d = S_ERR;
                end else if (misaligned) begin
                    error_d = 2'd2;
                    state_d = S_ERR;
                end else begin
                    state_d     = S_ISSUE;
                    mem_req_d   = 1'b1;
                    mem_we_d    = (cmd_q == 3'd3);
                    mem_addr_d  = tgt_word[ADDR_W-1:0];
                    mem_wdata_d = wdata_q;
                    mem_wstrb_d = wstrb_q;
                end
            end
            S_ISSUE: begin
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = (cmd_q == 3'd3) ? S_DONE : S_WAIT_R;
                end
            end
            S_WAIT_R: begin
                if (mem_rvalid) begin
                    if (cmd_q == 3'd1) inst_d = mem_rdata;
                    else               data_d = mem_rdata;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_INIT;
        endcase
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_INIT;
            init_cnt        <= CNT_LOAD;
            cmd_q           <= 3'd0;
            pc_q            <= '0;
            addr_q          <= '0;
            wdata_q         <= '0;
            wstrb_q         <= '0;
            ready           <= 1'b0;
            mem_start_ready <= 1'b0;
            error           <= 2'd0;
            mem_req         <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            mem_wstrb       <= '0;
            inst_rdata      <= 32'd63;
            data_rdata      <= '0;
        end else begin
            state           <= state_d;
            init_cnt        <= init_cnt_d;
            cmd_q           <= cmd_d;
            pc_q            <= pc_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            wstrb_q         <= wstrb_d;
            ready           <= ready_d;
            mem_start_ready <= msr_d;
            error           <= error_d;
            mem_req         <= mem_req_d;
            mem_we          <= mem_we_d;
            mem_addr        <= mem_addr_d;
            mem_wdata       <= mem_wdata_d;
            mem_wstrb       <= mem_wstrb_d;
            inst_rdata      <= inst_d;
            data_rdata      <= data_d;
        end
    end

endmodule

// File: tb/tb_agp32_mem_bridge.sv
// Bench for agp32_mem_bridge: memory responder plus a transaction-level model
// of what the core should observe, checked on every falling edge.
module tb_agp32_mem_bridge;
    localparam int ADDR_W      = 16;
    localparam int INIT_CYCLES = 8;

    logic              clk;
    logic              rst_n;
    logic [2:0]        command;
    logic [31:0]       pc, data_addr, data_wdata;
    logic [3:0]        data_wstrb;
    logic              ready, mem_start_ready, mem_req, mem_we;
    logic [31:0]       inst_rdata, data_rdata, mem_wdata, mem_rdata;
    logic [1:0]        error;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_wstrb;
    logic              mem_gnt, mem_rvalid;

    agp32_mem_bridge #(.ADDR_W(ADDR_W), .INIT_CYCLES(INIT_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .command(command), .pc(pc),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
        .ready(ready), .inst_rdata(inst_rdata), .data_rdata(data_rdata),
        .mem_start_ready(mem_start_ready), .error(error),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // model of the backing memory and of what the core should see
    logic [31:0] mem_model [int];
    logic [31:0] exp_inst = 32'd63;
    logic [31:0] exp_data = 32'd0;
    logic        exp_access = 1'b0;
    logic        exp_we = 1'b0;
    logic [31:0] exp_addr = '0, exp_wdata = '0;
    logic [3:0]  exp_wstrb = '0;
    logic [1:0]  exp_err = 2'd0;
    int          cur_cmd = 0, gdelay = 0, rdelay = 1;
    logic        aborted = 1'b0;
    int          stall_cnt = 0, req_cnt = 0, rv_cnt = 0, rv_addr = 0;

    function automatic logic [31:0] mem_rd(input int a);
        return mem_model.exists(a) ? mem_model[a] : 32'd0;
    endfunction

    // compare first, then act as the memory for the next rising edge
    initial begin
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            chk("inst_rdata", inst_rdata, exp_inst);
            chk("data_rdata", data_rdata, exp_data);
            if (!exp_access) chk("spurious_mem_req", 32'(mem_req), 32'd0);
            if (mem_req && exp_access) begin
                chk("mem_addr", 32'(mem_addr), exp_addr);
                chk("mem_we", 32'(mem_we), 32'(exp_we));
                if (exp_we) begin
                    chk("mem_wdata", mem_wdata, exp_wdata);
                    chk("mem_wstrb", 32'(mem_wstrb), 32'(exp_wstrb));
                end
            end
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hBAD0BAD0;
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_rd(rv_addr);
                    if (!aborted) begin
                        if (cur_cmd == 1) exp_inst = mem_rdata;
                        else              exp_data = mem_rdata;
                    end
                end
            end
            if (mem_req && rst_n) begin
                if (req_cnt == gdelay) begin
                    mem_gnt = 1'b1;
                    req_cnt = 0;
                    aborted = 1'b0;
                    if (mem_we) begin
                        logic [31:0] w;
                        w = mem_rd(int'(mem_addr));
                        for (int b = 0; b < 4; b++)
                            if (mem_wstrb[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                        mem_model[int'(mem_addr)] = w;
                    end else begin
                        rv_cnt  = rdelay;
                        rv_addr = int'(mem_addr);
                    end
                end else begin
                    req_cnt++;
                    stall_cnt++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic setup_expect(input logic [2:0] cmd, input logic [31:0] p, a, wd,
                                input logic [3:0] ws, input int gd, rd);
        logic [31:0] word;
        word = (cmd == 3'd1) ? (p >> 2) : (a >> 2);
        if (cmd >= 3'd5)                                      exp_err = 2'd3;
        else if (cmd != 3'd4 && word >= 32'(1 << ADDR_W))     exp_err = 2'd1;
        else if (cmd == 3'd3 && ws == 4'hF && a[1:0] != 2'b0) exp_err = 2'd2;
        else                                                  exp_err = 2'd0;
        exp_access = (exp_err == 2'd0) && (cmd >= 3'd1) && (cmd <= 3'd3);
        exp_addr   = word;
        exp_we     = (cmd == 3'd3);
        exp_wdata  = wd;
        exp_wstrb  = ws;
        cur_cmd    = int'(cmd);
        gdelay     = gd;
        rdelay     = rd;
        stall_cnt  = 0;
        req_cnt    = 0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 50) begin @(negedge clk); n++; end
        if (!ready) begin errors++; checks++; $display("FAIL wait_ready: got timeout expected ready"); end
    endtask

    task automatic issue(input logic [2:0] cmd, input logic [31:0] p, a, wd,
                         input logic [3:0] ws, input int gd, rd, output int lat);
        wait_ready();
        setup_expect(cmd, p, a, wd, ws, gd, rd);
        command = cmd; pc = p; data_addr = a; data_wdata = wd; data_wstrb = ws;
        @(negedge clk);
        command = 3'd0; pc = 32'hFFFF_FFFF; data_addr = 32'hFFFF_FFFF;
        data_wdata = 32'h5555_5555; data_wstrb = 4'h0;
        lat = 1;
        chk("ready_drop", 32'(ready), 32'd0);
        while (!ready && error == 2'd0 && lat < 60) begin @(negedge clk); lat++; end
        if (lat >= 60) begin errors++; checks++; $display("FAIL issue_timeout: got no completion expected completion"); end
        chk("error", 32'(error), 32'(exp_err));
        exp_access = 1'b0;
    endtask

    task automatic assert_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0; command = 3'd0;
        exp_inst = 32'd63; exp_data = 32'd0; exp_access = 1'b0; aborted = 1'b1;
        #1;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_msr", 32'(mem_start_ready), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_inst", inst_rdata, 32'h0000_003F);
        chk("rst_data", data_rdata, 32'd0);
    endtask

    task automatic release_init();
        int n = 0;
        @(negedge clk);
        rst_n = 1'b1;
        command = 3'd2; data_addr = 32'h10;   // must be ignored during INIT
        while (!mem_start_ready && n < 30) begin
            @(negedge clk);
            n++;
            command = 3'd0;
        end
        chk("init_cycles", 32'(n), 32'd8);
        chk("init_ready", 32'(ready), 32'd1);
        chk("init_inst", inst_rdata, 32'h0000_003F);
    endtask

    task automatic full_reset();
        assert_reset();
        repeat (2) @(negedge clk);
        release_init();
    endtask

    int lat;

    initial begin
        rst_n = 1'b0; command = 3'd0; pc = '0; data_addr = '0;
        data_wdata = '0; data_wstrb = '0;
        mem_model[4] = 32'hDEAD_BEEF;
        mem_model[8] = 32'h1122_3344;
        repeat (3) @(negedge clk);
        chk("por_ready", 32'(ready), 32'd0);
        chk("por_inst", inst_rdata, 32'h0000_003F);
        chk("por_mem_req", 32'(mem_req), 32'd0);
        release_init();

        issue(3'd1, 32'h10, 32'h0, 32'h0, 4'h0, 0, 2, lat);
        chk("fetch_lat", 32'(lat), 32'd6);
        chk("fetch_inst", inst_rdata, 32'hDEAD_BEEF);

        issue(3'd3, 32'h0, 32'h21, 32'h0000_AB00, 4'b0010, 3, 1, lat);
        chk("wr_lat", 32'(lat), 32'd7);
        chk("wr_stall", 32'(stall_cnt), 32'd3);

        issue(3'd2, 32'h0, 32'h23, 32'h0, 4'h0, 0, 1, lat);
        chk("rd_lat", 32'(lat), 32'd5);
        chk("rd_merged", data_rdata, 32'h1122_AB44);

        issue(3'd4, 32'h0, 32'h0, 32'h0, 4'h0, 0, 1, lat);
        chk("int_lat", 32'(lat), 32'd3);
        chk("int_inst_hold", inst_rdata, 32'hDEAD_BEEF);

        issue(3'd3, 32'h0, 32'h30, 32'hFFFF_FFFF, 4'h0, 1, 1, lat);
        chk("wstrb0_lat", 32'(lat), 32'd5);
        issue(3'd3, 32'h0, 32'h40, 32'hCAFE_F00D, 4'hF, 0, 1, lat);
        issue(3'd1, 32'h42, 32'h0, 32'h0, 4'h0, 2, 3, lat);
        chk("fetch2_inst", inst_rdata, 32'hCAFE_F00D);
        issue(3'd2, 32'h0, 32'h32, 32'h0, 4'h0, 0, 1, lat);
        chk("wstrb0_nochange", data_rdata, 32'd0);
        issue(3'd2, 32'h0, 32'h20, 32'h0, 4'h0, 0, 1, lat);

        // reset while a read is waiting for rvalid
        wait_ready();
        setup_expect(3'd2, 32'h0, 32'h10, 32'h0, 4'h0, 0, 6);
        command = 3'd2; data_addr = 32'h10;
        @(negedge clk);
        command = 3'd0;
        @(negedge clk);
        assert_reset();
        repeat (2) @(negedge clk);
        release_init();
        chk("late_rvalid_data", data_rdata, 32'd0);

        issue(3'd3, 32'h0, 32'h22, 32'h1234_5678, 4'hF, 0, 1, lat);
        chk("misalign_err", 32'(error), 32'd2);
        repeat (3) begin
            @(negedge clk);
            chk("err_ready_low", 32'(ready), 32'd0);
            chk("err_sticky", 32'(error), 32'd2);
        end
        full_reset();
        chk("err_cleared", 32'(error), 32'd0);

        issue(3'd2, 32'h0, 32'h0004_0000, 32'h0, 4'h0, 0, 1, lat);
        chk("range_err", 32'(error), 32'd1);
        full_reset();
        issue(3'd1, 32'h0004_0000, 32'h10, 32'h0, 4'h0, 0, 1, lat);
        full_reset();
        issue(3'd3, 32'h0, 32'h0004_0002, 32'h0, 4'hF, 0, 1, lat);
        full_reset();
        issue(3'd6, 32'h0, 32'h0004_0000, 32'h0, 4'h0, 0, 1, lat);
        chk("illegal_err", 32'(error), 32'd3);
        full_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
